// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel
//   NUM_CH independent PWM outputs driven from one shared period counter, with
//   optional per-channel phase stagger. Duty is set through a write port or
//   stepped with two debounced push buttons. Duty changes are double-buffered:
//   the pending duty (duty_q) is copied into the active duty only on the last
//   cycle of each channel's own period, so an output never produces a runt pulse.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   increase_duty   raw push button, +STEP on channel ch_sel
//   decrease_duty   raw push button, -STEP on channel ch_sel
//   ch_sel          channel targeted by the buttons and by duty_rd
//   wr_en           single-cycle duty write strobe (wins over the buttons)
//   wr_ch, wr_data  channel and duty (counts, clamped to PERIOD) to write
//   duty_rd         pending duty of ch_sel (combinational)
//   pwm_out         registered PWM outputs, one per channel
//   period_start    one-cycle pulse in the same cycle as the outputs for cnt==0
module pwm_multi_channel #(
  parameter int NUM_CH        = 4,
  parameter int PERIOD        = 10,
  parameter int DUTY_INIT     = PERIOD / 2,
  parameter int STEP          = 1,
  parameter int DEBOUNCE_DIV  = 25000000,
  parameter int PHASE_STAGGER = 0,
  localparam int DW = $clog2(PERIOD + 1),
  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              increase_duty,
  input  logic              decrease_duty,
  input  logic [SW-1:0]     ch_sel,
  input  logic              wr_en,
  input  logic [SW-1:0]     wr_ch,
  input  logic [DW-1:0]     wr_data,
  output logic [DW-1:0]     duty_rd,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start
);

  localparam int VW = $clog2(DEBOUNCE_DIV);
  localparam logic [DW-1:0] PERIOD_D = DW'(PERIOD);
  localparam logic [DW-1:0] LAST_CNT = DW'(PERIOD - 1);
  localparam logic [VW-1:0] LAST_DIV = VW'(DEBOUNCE_DIV - 1);

  logic [VW-1:0] div_q;
  logic [DW-1:0] cnt_q;
  // Debounce samplers, bit 0 = increase button, bit 1 = decrease button
  logic [1:0]    s1_q;
  logic [1:0]    s2_q;
  logic          periodStart_q;
  logic [DW-1:0] duty_q [NUM_CH];
  logic [DW-1:0] duty_d [NUM_CH];

  logic          tick;
  logic [1:0]    press;
  logic          selValid;
  logic          wrValid;
  logic [DW-1:0] selDuty;
  logic [DW-1:0] wrClamped;
  logic [DW-1:0] incClamped;
  logic [DW-1:0] decClamped;
  logic [31:0]   incWide;

  assign tick  = (div_q == LAST_DIV);
  // A press is a rising edge seen between two consecutive ticks, so a held
  // button produces exactly one pulse.
  assign press = s1_q & ~s2_q & {2{tick}};

  // Channel indices beyond NUM_CH-1 are possible when NUM_CH is not a power
  // of two; such selects read as zero and writes to them are ignored.
  assign selValid = ({1'b0, ch_sel} < (SW + 1)'(NUM_CH));
  assign wrValid  = ({1'b0, wr_ch}  < (SW + 1)'(NUM_CH));
  assign selDuty  = selValid ? duty_q[ch_sel] : '0;
  assign duty_rd  = selDuty;

  // Saturating arithmetic is done 32 bits wide so neither the sum can wrap
  // nor the difference underflow, whatever STEP is.
  assign wrClamped  = (wr_data > PERIOD_D) ? PERIOD_D : wr_data;
  assign incWide    = 32'(selDuty) + 32'(STEP);
  assign incClamped = (incWide > 32'(PERIOD)) ? PERIOD_D : DW'(incWide);
  assign decClamped = (32'(selDuty) >= 32'(STEP)) ? DW'(32'(selDuty) - 32'(STEP)) : '0;

  // Pending-duty update: a write wins and swallows any button pulse in the
  // same cycle; simultaneous increase and decrease cancel out.
  always_comb begin
    duty_d = duty_q;
    if (wr_en) begin
      if (wrValid) duty_d[wr_ch] = wrClamped;
    end else if (selValid && press == 2'b01) begin
      duty_d[ch_sel] = incClamped;
    end else if (selValid && press == 2'b10) begin
      duty_d[ch_sel] = decClamped;
    end
  end

  // Shared timing: debounce tick divider, period counter, button samplers,
  // pending duties and the period-start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      cnt_q         <= '0;
      s1_q          <= '0;
      s2_q          <= '0;
      periodStart_q <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) duty_q[k] <= DW'(DUTY_INIT);
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      cnt_q <= (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
      if (tick) begin
        s1_q <= {decrease_duty, increase_duty};
        s2_q <= s1_q;
      end
      periodStart_q <= (cnt_q == '0);
      duty_q        <= duty_d;
    end
  end

  assign period_start = periodStart_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : gChannel
    localparam int PHASE = (PHASE_STAGGER != 0) ? (i * PERIOD) / NUM_CH : 0;

    logic [DW-1:0] chCount;
    logic [DW-1:0] dutyAct_q;
    logic          pwmBit_q;

    // Channel-local position in its period: (cnt - PHASE) mod PERIOD.
    if (PHASE == 0) begin : gNoShift
      assign chCount = cnt_q;
    end else begin : gShift
      assign chCount = (cnt_q >= DW'(PHASE)) ? cnt_q - DW'(PHASE)
                                             : cnt_q + DW'(PERIOD - PHASE);
    end

    // The active duty reloads on the channel's own last cycle; the compare on
    // that same edge still uses the old duty, so the new value starts cleanly
    // at local count 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dutyAct_q <= DW'(DUTY_INIT);
        pwmBit_q  <= 1'b0;
      end else begin
        if (chCount == LAST_CNT) dutyAct_q <= duty_q[i];
        pwmBit_q <= (chCount < dutyAct_q);
      end
    end

    assign pwm_out[i] = pwmBit_q;
  end

endmodule
